// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte-level transform functions
// (SubBytes, ShiftRows, MixColumns, AddRoundKey, key-schedule helpers).
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] AES_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return AES_SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round constant for key-schedule step j (j >= 1): 01, 02, 04 ... 1b, 36.
  function automatic logic [7:0] rcon(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < j; k++) r = xtime(r);
    return r;
  endfunction

  function automatic aes_block_t sub_bytes(input aes_block_t s);
    aes_block_t o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte k = 4*col + row sits at bits [127-8k -: 8]; row r rotates left by r.
  function automatic aes_block_t shift_rows(input aes_block_t s);
    aes_block_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic aes_block_t mix_columns(input aes_block_t s);
    aes_block_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic aes_block_t add_round_key(input aes_block_t s, input aes_block_t k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_key_expand.sv
// Combinational AES key expansion for NK = 4/6/8; presents all NR+1
// round keys in parallel so the core can pick one per round.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic [32*NK-1:0] key,
  output aes_block_t       rk [NR+1]
);

  localparam int NW = 4 * (NR + 1);

  for (genvar i = 0; i < NW; i++) begin : g_w
    logic [31:0] w;
    if (i < NK) begin : g_key
      assign w = key[32*(NK-i)-1 -: 32];
    end else if (i % NK == 0) begin : g_rcon
      assign w = g_w[i-NK].w
               ^ sub_word({g_w[i-1].w[23:0], g_w[i-1].w[31:24]})
               ^ {rcon(i / NK), 24'h000000};
    end else if (NK > 6 && i % NK == 4) begin : g_sub
      assign w = g_w[i-NK].w ^ sub_word(g_w[i-1].w);
    end else begin : g_xor
      assign w = g_w[i-NK].w ^ g_w[i-1].w;
    end
  end

  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign rk[r] = {g_w[4*r].w, g_w[4*r+1].w, g_w[4*r+2].w, g_w[4*r+3].w};
  end

endmodule

// File: rtl/aes_round.sv
// One combinational AES round; last_round drops MixColumns.
module aes_round
  import aes_pkg::*;
(
  input  aes_block_t state_in,
  input  aes_block_t round_key,
  input  logic       last_round,
  output aes_block_t state_out
);

  aes_block_t sr;

  assign sr        = shift_rows(sub_bytes(state_in));
  assign state_out = add_round_key(last_round ? sr : mix_columns(sr), round_key);

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core, one round per clock, NK = 4/6/8.
// Define AES_CIPHER_DBG_EN to expose dbg_round / dbg_state.
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  aes_block_t       in_block,
  input  logic [32*NK-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output aes_block_t       out_block,
`ifdef AES_CIPHER_DBG_EN
  output logic             busy,
  output logic [3:0]       dbg_round,
  output aes_block_t       dbg_state
`else
  output logic             busy
`endif
);

  localparam int         NR   = nr_of(NK);
  localparam logic [3:0] NR_L = 4'(NR);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_cipher_iter: NK must be 4, 6 or 8");
  end

  aes_state_e       st_q, st_d;
  logic [3:0]       rnd;
  logic [32*NK-1:0] key_q;
  aes_block_t       state_q;
  aes_block_t       round_out;
  aes_block_t       rk [NR+1];
  logic             accept;
  logic             last_round;

  assign accept     = in_valid && in_ready;
  assign last_round = (rnd == NR_L);

  aes_key_expand #(.NK(NK), .NR(NR)) u_key_expand (
    .key (key_q),
    .rk  (rk)
  );

  aes_round u_round (
    .state_in   (state_q),
    .round_key  (rk[rnd]),
    .last_round (last_round),
    .state_out  (round_out)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  // Next state: DONE can hand straight over to a new block in the same cycle
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (accept) st_d = ROUND;
      ROUND:   if (last_round) st_d = DONE;
      DONE:    if (out_ready) st_d = in_valid ? ROUND : IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Handshake outputs; in_ready deliberately independent of in_valid
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (st_q)
      IDLE:    in_ready = 1'b1;
      ROUND:   busy     = 1'b1;
      DONE:    in_ready = out_ready;
      default: ;
    endcase
  end

  // Datapath: round-0 AddRoundKey on accept, then one round per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q     <= '0;
      state_q   <= '0;
      rnd       <= '0;
      out_block <= '0;
      out_valid <= 1'b0;
    end else begin
      if (st_q == DONE && out_ready) out_valid <= 1'b0;
      if (accept) begin
        key_q   <= in_key;
        state_q <= in_block ^ in_key[32*NK-1 -: 128];
        rnd     <= 4'd1;
      end else if (st_q == ROUND) begin
        state_q <= round_out;
        if (last_round) begin
          out_block <= round_out;
          out_valid <= 1'b1;
          rnd       <= '0;
        end else begin
          rnd <= rnd + 4'd1;
        end
      end
    end
  end

`ifdef AES_CIPHER_DBG_EN
  assign dbg_round = (st_q == IDLE) ? 4'd0 : rnd;
  assign dbg_state = state_q;
`endif

endmodule
